// File: rtl/fb_cpu_pkg.sv
// fb_cpu_pkg: shared definitions for the fb_cpu_v2 accumulator CPU.
//   - OPCODE_WIDTH : width of the instruction opcode field (4)
//   - OP_*         : opcode values
//   - ST_*         : FSM state encodings (3-bit, 5..7 unused)
//   - is_mem_op()  : opcodes that need a data RAM read/write in the MEM state
package fb_cpu_pkg;

  localparam int OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_LOD = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMZ = 4'd7;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'd9;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 4'd10;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = 4'd11;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMN = 4'd12;
  localparam logic [OPCODE_WIDTH-1:0] OP_ILL = 4'd13;
  localparam logic [OPCODE_WIDTH-1:0] OP_CAL = 4'd14;
  localparam logic [OPCODE_WIDTH-1:0] OP_RET = 4'd15;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Opcodes 0-5 and 10-11 touch data memory and take the extra MEM cycle.
  function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] opcode);
    return (opcode <= OP_DIV) || (opcode == OP_AND) || (opcode == OP_OR);
  endfunction

endpackage

// File: rtl/fb_cpu_v2_alu.sv
// fb_cpu_v2_alu: combinational accumulator ALU for fb_cpu_v2.
// Ports:
//   opcode  in  OPCODE_WIDTH  current instruction opcode
//   acc     in  DATA_WIDTH    accumulator value
//   data    in  DATA_WIDTH    operand word read from RAM
//   result  out DATA_WIDTH    new accumulator value (acc for non-ALU opcodes)
//   div0    out 1             DIV with a zero divisor
// All arithmetic is unsigned and wraps modulo 2^DATA_WIDTH.
module fb_cpu_v2_alu
  import fb_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   acc,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    div0
);

  always_comb begin
    result = acc;
    div0   = 1'b0;
    case (opcode)
      OP_LOD: result = data;
      OP_ADD: result = acc + data;
      OP_SUB: result = acc - data;
      // Self-determined DATA_WIDTH product keeps only the low bits.
      OP_MUL: result = acc * data;
      OP_DIV: begin
        if (data == '0) begin
          result = '1;
          div0   = 1'b1;
        end else begin
          result = acc / data;
        end
      end
      OP_AND: result = acc & data;
      OP_OR:  result = acc | data;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/fb_cpu_v2.sv
// fb_cpu_v2: multi-cycle accumulator CPU (FETCH/DECODE/EXEC/MEM/HALT) driving
// a single-port synchronous block RAM with one-cycle read latency.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset; also gates RAM outputs to 0
//   MAR       out  RAM address
//   MDRIn     out  RAM write data
//   RAMWr     out  RAM write enable
//   MDROut    in   RAM read data (for the address presented last cycle)
//   PC        out  program counter
//   ACC       out  accumulator
//   halted    out  high in HALT state
//   illegal   out  sticky undefined-opcode flag
//   div_zero  out  sticky divide-by-zero flag
// Optional build macro: FB_CPU_CALL_EN adds a LINK register and the
// CAL (14) / RET (15) instructions; without it both opcodes are illegal.
module fb_cpu_v2
  import fb_cpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] MAR,
  output logic [DATA_WIDTH-1:0]    MDRIn,
  output logic                     RAMWr,
  input  logic [DATA_WIDTH-1:0]    MDROut,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0]    ACC,
  output logic                     halted,
  output logic                     illegal,
  output logic                     div_zero
);

  if (DATA_WIDTH < ADDRESS_WIDTH + OPCODE_WIDTH) begin : g_width_check
    $error("fb_cpu_v2: DATA_WIDTH must be >= ADDRESS_WIDTH+4");
  end

  logic [2:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0]    ir_q, ir_d;
  logic [DATA_WIDTH-1:0]    acc_q, acc_d;
  logic                     illegal_q, illegal_d;
  logic                     div_zero_q, div_zero_d;
`ifdef FB_CPU_CALL_EN
  logic [ADDRESS_WIDTH-1:0] link_q, link_d;
`endif

  logic [ADDRESS_WIDTH-1:0] mar_c;
  logic [DATA_WIDTH-1:0]    mdr_c;
  logic                     wr_c;

  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [ADDRESS_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0]    alu_result;
  logic                     alu_div0;

  // IR bits above the opcode field are intentionally ignored.
  assign opcode  = ir_q[ADDRESS_WIDTH+OPCODE_WIDTH-1:ADDRESS_WIDTH];
  assign operand = ir_q[ADDRESS_WIDTH-1:0];

  fb_cpu_v2_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .opcode (opcode),
    .acc    (acc_q),
    .data   (MDROut),
    .result (alu_result),
    .div0   (alu_div0)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    acc_d      = acc_q;
    illegal_d  = illegal_q;
    div_zero_d = div_zero_q;
`ifdef FB_CPU_CALL_EN
    link_d     = link_q;
`endif
    mar_c      = '0;
    mdr_c      = '0;
    wr_c       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mar_c   = pc_q;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        ir_d    = MDROut;
        pc_d    = pc_q + 1'b1;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        if (is_mem_op(opcode)) begin
          // Present the operand address now so the data is on MDROut in MEM.
          mar_c   = operand;
          state_d = ST_MEM;
        end else begin
          state_d = ST_FETCH;
          case (opcode)
            OP_JMP: pc_d = operand;
            OP_JMZ: if (acc_q == '0) pc_d = operand;
            OP_JMN: if (acc_q[DATA_WIDTH-1]) pc_d = operand;
            OP_NOP: ;
            OP_HLT: state_d = ST_HALT;
`ifdef FB_CPU_CALL_EN
            // pc_q already points past the CAL, so it is the return address.
            OP_CAL: begin
              link_d = pc_q;
              pc_d   = operand;
            end
            OP_RET: pc_d = link_q;
`endif
            default: illegal_d = 1'b1;
          endcase
        end
      end

      ST_MEM: begin
        state_d = ST_FETCH;
        if (opcode == OP_STO) begin
          mar_c = operand;
          mdr_c = acc_q;
          wr_c  = 1'b1;
        end else begin
          acc_d = alu_result;
          if (alu_div0) div_zero_d = 1'b1;
        end
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      acc_q      <= '0;
      illegal_q  <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef FB_CPU_CALL_EN
      link_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      acc_q      <= acc_d;
      illegal_q  <= illegal_d;
      div_zero_q <= div_zero_d;
`ifdef FB_CPU_CALL_EN
      link_q     <= link_d;
`endif
    end
  end

  // RAM-facing outputs are gated by rst_n so a write in flight dies at once.
  assign MAR      = rst_n ? mar_c : '0;
  assign MDRIn    = rst_n ? mdr_c : '0;
  assign RAMWr    = rst_n ? wr_c  : 1'b0;

  assign PC       = pc_q;
  assign ACC      = acc_q;
  assign halted   = (state_q == ST_HALT);
  assign illegal  = illegal_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_fb_cpu_v2.sv
// tb_fb_cpu_v2: scoreboard bench for fb_cpu_v2. An instruction-level model
// predicts every RAM write and the final architectural state of each program;
// a monitor compares them as the DUT produces writes and reaches HALT.
module tb_fb_cpu_v2;
  localparam int AW = 6;
  localparam int DW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    bit            ill;
    bit            dz;
    int            cyc;
  } fin_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] MAR;
  logic [DW-1:0] MDRIn;
  logic          RAMWr;
  logic [DW-1:0] MDROut;
  logic [AW-1:0] PC;
  logic [DW-1:0] ACC;
  logic          halted, illegal, div_zero;

  fb_cpu_v2 #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .MAR(MAR), .MDRIn(MDRIn), .RAMWr(RAMWr),
    .MDROut(MDROut), .PC(PC), .ACC(ACC), .halted(halted),
    .illegal(illegal), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with one-cycle read latency.
  logic [DW-1:0] ram [64];
  logic [DW-1:0] img [64];
  logic          load_req;
  int            cyc;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 64; i++) ram[i] <= img[i];
    end else if (RAMWr) begin
      ram[MAR] <= MDRIn;
    end
    MDROut <= ram[MAR];
  end

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int   pass_cnt = 0;
  int   total_cnt = 0;
  wr_t  exp_wr_q[$];
  fin_t fin_q[$];
  bit   mon_en;

  logic [DW-1:0] mdl_mem [64];
  wr_t  mdl_wr[$];
  fin_t mdl_fin;

  wr_t  m_e;
  fin_t m_f;
  bit   m_hs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [DW-1:0] ins(input int op, input int a);
    return DW'(op * 64 + a);
  endfunction

  // Instruction-level reference: executes img, counting 4 cycles for
  // memory-class instructions and 3 for everything else.
  task automatic run_model(output bit ok);
    int pc, acc, link, m, op, a, cycles;
    bit ill, dz;
    pc = 0; acc = 0; link = 0; ill = 0; dz = 0; cycles = 0; ok = 0;
    mdl_wr.delete();
    for (int i = 0; i < 64; i++) mdl_mem[i] = img[i];
    for (int n = 0; n < 300 && !ok; n++) begin
      op = int'(mdl_mem[pc]) / 64;
      a  = int'(mdl_mem[pc]) % 64;
      pc = (pc + 1) % 64;
      if (op <= 5 || op == 10 || op == 11) begin
        cycles += 4;
        m = int'(mdl_mem[a]);
        case (op)
          0: acc = m;
          1: begin mdl_mem[a] = DW'(acc); mdl_wr.push_back('{AW'(a), DW'(acc)}); end
          2: acc = (acc + m) % 1024;
          3: acc = (acc - m + 1024) % 1024;
          4: acc = (acc * m) % 1024;
          5: if (m == 0) begin acc = 1023; dz = 1; end else acc = acc / m;
          10: acc = acc & m;
          default: acc = acc | m;
        endcase
      end else begin
        cycles += 3;
        case (op)
          6: pc = a;
          7: if (acc == 0) pc = a;
          12: if (acc >= 512) pc = a;
          8: ;
          9: ok = 1;
`ifdef FB_CPU_CALL_EN
          14: begin link = pc; pc = a; end
          15: pc = link;
`endif
          default: ill = 1;
        endcase
      end
    end
    mdl_fin = '{AW'(pc), DW'(acc), ill, dz, cycles};
  endtask

  task automatic blank_img();
    for (int i = 0; i < 40; i++) img[i] = ins(9, 0);
    for (int i = 40; i < 64; i++) img[i] = '0;
  endtask

  task automatic load_ram();
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // Reset, load, predict, release, wait for HALT, then audit the scoreboard.
  task automatic run_prog(input string tag);
    bit ok;
    int bad;
    @(negedge clk);
    rst_n = 1'b0;
    mon_en = 1'b1;
    #1;
    check({tag, ":rst_pc"}, PC, 0);
    check({tag, ":rst_acc"}, ACC, 0);
    check({tag, ":rst_flags"}, {halted, illegal, div_zero}, 0);
    check({tag, ":rst_ramwr"}, RAMWr, 0);
    load_ram();
    run_model(ok);
    check({tag, ":model_halts"}, ok, 1);
    foreach (mdl_wr[i]) exp_wr_q.push_back(mdl_wr[i]);
    fin_q.push_back(mdl_fin);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2000 && !halted; k++) @(negedge clk);
    check({tag, ":halt_reached"}, halted, 1);
    @(negedge clk);
    @(negedge clk);
    check({tag, ":writes_pending"}, exp_wr_q.size(), 0);
    check({tag, ":final_pending"}, fin_q.size(), 0);
    exp_wr_q.delete();
    fin_q.delete();
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== mdl_mem[i]) bad++;
    check({tag, ":mem_image"}, bad, 0);
  endtask

  task automatic gen_random();
    int op, a;
    bit ok;
    for (int tries = 0; tries < 200; tries++) begin
      blank_img();
      for (int i = 0; i < 24; i++) begin
        op = $urandom_range(0, 15);
        if (op <= 5 || op == 10 || op == 11) a = $urandom_range(40, 63);
        else a = $urandom_range(0, 39);
        img[i] = ins(op, a);
      end
      for (int i = 40; i < 64; i++)
        img[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(0, 1023));
      run_model(ok);
      if (ok) break;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load_req = 1'b0;
    mon_en = 1'b0;
    m_hs = 1'b0;
    fork
      begin
        forever begin
          @(negedge clk);
          if (!rst_n) m_hs = 1'b0;
          else if (mon_en) begin
            if (RAMWr) begin
              if (exp_wr_q.size() == 0) check("unexpected_write", MAR, 0);
              else begin
                m_e = exp_wr_q.pop_front();
                check("wr_addr", MAR, m_e.addr);
                check("wr_data", MDRIn, m_e.data);
              end
            end
            if (halted && !m_hs) begin
              m_hs = 1'b1;
              if (fin_q.size() == 0) check("unexpected_halt", halted, 0);
              else begin
                m_f = fin_q.pop_front();
                check("final_pc", PC, m_f.pc);
                check("final_acc", ACC, m_f.acc);
                check("final_illegal", illegal, m_f.ill);
                check("final_div_zero", div_zero, m_f.dz);
                check("halt_cycles", cyc, m_f.cyc);
              end
            end
          end
        end
      end
      begin
        repeat (3) @(negedge clk);

        blank_img();
        img[0] = ins(0, 50); img[1] = ins(2, 51); img[2] = ins(1, 52); img[3] = ins(9, 0);
        img[50] = 5; img[51] = 10;
        run_prog("add");
        check("add:mem52", ram[52], 15);

        blank_img();
        img[0] = ins(0, 50); img[1] = ins(5, 53); img[2] = ins(1, 52); img[3] = ins(9, 0);
        img[50] = 5; img[53] = 0;
        run_prog("div0");
        check("div0:mem52", ram[52], 10'h3FF);
        check("div0:flags", {illegal, div_zero}, 2'b01);

        blank_img();
        img[0] = ins(0, 52); img[1] = ins(2, 50); img[2] = ins(1, 52);
        img[3] = ins(0, 53); img[4] = ins(3, 54); img[5] = ins(1, 53);
        img[6] = ins(7, 8); img[7] = ins(6, 0); img[8] = ins(9, 0);
        img[50] = 5; img[52] = 0; img[53] = 10; img[54] = 1;
        run_prog("loop");
        check("loop:mem52", ram[52], 50);

        blank_img();
        img[0] = ins(0, 50); img[1] = ins(3, 51); img[2] = ins(12, 10);
        img[50] = 5; img[51] = 10;
        run_prog("jmn_taken");
        check("jmn_taken:acc", ACC, 10'h3FB);
        img[51] = 3;
        run_prog("jmn_fall");

        blank_img();
        img[0] = ins(0, 50); img[1] = ins(13, 0); img[2] = ins(1, 52); img[3] = ins(9, 0);
        img[50] = 5;
        run_prog("op13");
        check("op13:mem52", ram[52], 5);
        img[1] = ins(14, 20); img[20] = ins(15, 0);
        run_prog("op14");

        // Reset asserted during the STO write cycle.
        blank_img();
        img[0] = ins(0, 50); img[1] = ins(1, 52); img[2] = ins(9, 0);
        img[50] = 5; img[52] = 10'h155;
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        load_ram();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 60 && !RAMWr; k++) @(negedge clk);
        check("rststo:wr_seen", {RAMWr, MAR, MDRIn}, {1'b1, 6'd52, 10'd5});
        rst_n = 1'b0;
        #1;
        check("rststo:wr_killed", {RAMWr, MAR, MDRIn}, 0);
        check("rststo:pc_acc", {PC, ACC}, 0);
        @(negedge clk);
        check("rststo:mem52_kept", ram[52], 10'h155);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rststo:post_pc_acc", {PC, ACC, halted}, 0);
        for (int k = 0; k < 60 && !halted; k++) @(negedge clk);
        check("rststo:rerun_mem52", ram[52], 5);
        check("rststo:rerun_pc", PC, 3);

        for (int t = 0; t < 20; t++) begin
          gen_random();
          run_prog($sformatf("rand%0d", t));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
      end
    join
  end

endmodule
